// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - single-digit BCD counter with prescaler, load and seven-segment decode
module bcd_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Load,
  input  logic [3:0] Din,
  output logic [3:0] Q,
  output logic       Co,
  output logic [7:0] Q_seg
);

  // Prescaler terminal value; with TICK_DIV=1 it is 0 and every cycle ticks.
  localparam logic [15:0] PRESCALE_LAST = 16'(TICK_DIV - 1);

  logic [3:0]  count;
  logic [15:0] prescale;
  logic        tick;

  assign tick = (prescale == PRESCALE_LAST);

  // Prescaler: restarts on load so step spacing is measured from the load edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= 16'd0;
    end else if (Load) begin
      prescale <= 16'd0;
    end else if (tick) begin
      prescale <= 16'd0;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // Count register: load wins over tick; non-BCD load values are coerced to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (Load) begin
      count <= (Din > 4'd9) ? 4'd0 : Din;
    end else if (tick) begin
      count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
    end
  end

  assign Q  = count;
  assign Co = (count == 4'd9) && tick && !Load;

  // Seven-segment decode of the live count; dp is never lit, 10..15 blank.
  always_comb begin
    Q_seg = 8'h00;
    case (count)
      4'd0:    Q_seg = 8'h3F;
      4'd1:    Q_seg = 8'h06;
      4'd2:    Q_seg = 8'h5B;
      4'd3:    Q_seg = 8'h4F;
      4'd4:    Q_seg = 8'h66;
      4'd5:    Q_seg = 8'h6D;
      4'd6:    Q_seg = 8'h7D;
      4'd7:    Q_seg = 8'h07;
      4'd8:    Q_seg = 8'h7F;
      4'd9:    Q_seg = 8'h6F;
      default: Q_seg = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - randomized and directed checks of bcd_counter against a behavioural model
module tb_bcd_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic [3:0] q1, q4;
  logic       co1, co4;
  logic [7:0] seg1, seg4;

  int n_vec;
  int n_err;

  // Behavioural model: index 0 is the TICK_DIV=1 instance, index 1 is TICK_DIV=4.
  int m_cnt [2];
  int m_ph  [2];
  int divs  [2];
  logic [7:0] seg_tab [10];

  bcd_counter #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .Load(load), .Din(din), .Q(q1), .Co(co1), .Q_seg(seg1)
  );

  bcd_counter #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .Load(load), .Din(din), .Q(q4), .Co(co4), .Q_seg(seg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_tick(int i);
    return (m_ph[i] % divs[i]) == (divs[i] - 1);
  endfunction

  function automatic logic m_co(int i, logic l);
    return (m_cnt[i] == 9) && m_tick(i) && !l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_ph[i]  = 0;
    end
  endtask

  task automatic model_edge(input logic l, input logic [3:0] d);
    for (int i = 0; i < 2; i++) begin
      if (l) begin
        m_cnt[i] = (d < 10) ? int'(d) : 0;
        m_ph[i]  = 0;
      end else begin
        if (m_tick(i)) m_cnt[i] = (m_cnt[i] + 1) % 10;
        m_ph[i] = m_ph[i] + 1;
      end
    end
  endtask

  // Called at the falling edge; applies inputs across one rising edge and returns at the next falling edge.
  task automatic edge_step(input logic l, input logic [3:0] d);
    load = l;
    din  = d;
    @(posedge clk);
    model_edge(l, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    load = 1'b0;
    din  = 4'd0;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    edge_step(1'b1, 4'd7);
    edge_step(1'b0, 4'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (q1 !== 4'd0) begin n_err++; $display("FAIL reset_q1: got %0d expected 0", q1); end
    n_vec++; if (seg1 !== 8'h3F) begin n_err++; $display("FAIL reset_seg1: got %0h expected 3f", seg1); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL reset_co1: got %0b expected 0", co1); end
    n_vec++; if (q4 !== 4'd0 || seg4 !== 8'h3F) begin n_err++; $display("FAIL reset_q4: got %0d/%0h expected 0/3f", q4, seg4); end
    @(negedge clk);
    load = 1'b1;
    din  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (q1 !== 4'd0 || q4 !== 4'd0) begin n_err++; $display("FAIL reset_ignores_load: got %0d/%0d expected 0/0", q1, q4); end
    rst  = 1'b0;
    load = 1'b0;
    #1;
    for (int e = 0; e < 3; e++) edge_step(1'b0, 4'd0);
    n_vec++; if (q1 !== 4'd3 || seg1 !== 8'h4F) begin n_err++; $display("FAIL reset_release: got %0d/%0h expected 3/4f", q1, seg1); end
    n_vec++; if (q4 !== 4'd0) begin n_err++; $display("FAIL reset_release_div4: got %0d expected 0", q4); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int e = 0; e < 9; e++) edge_step(1'b0, 4'd0);
    n_vec++; if (q1 !== 4'd9 || seg1 !== 8'h6F) begin n_err++; $display("FAIL wrap_nine: got %0d/%0h expected 9/6f", q1, seg1); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL wrap_co_high: got %0b expected 1", co1); end
    edge_step(1'b0, 4'd0);
    n_vec++; if (q1 !== 4'd0 || co1 !== 1'b0) begin n_err++; $display("FAIL wrap_zero: got %0d/%0b expected 0/0", q1, co1); end
  endtask

  task automatic test_load();
    edge_step(1'b1, 4'd7);
    n_vec++; if (q1 !== 4'd7) begin n_err++; $display("FAIL load_seven: got %0d expected 7", q1); end
    edge_step(1'b1, 4'd4);
    n_vec++; if (q1 !== 4'd4 || seg1 !== 8'h66) begin n_err++; $display("FAIL load_four: got %0d/%0h expected 4/66", q1, seg1); end
    edge_step(1'b0, 4'd4);
    n_vec++; if (q1 !== 4'd5) begin n_err++; $display("FAIL load_then_count: got %0d expected 5", q1); end
  endtask

  task automatic test_load_priority();
    edge_step(1'b1, 4'd9);
    load = 1'b1;
    din  = 4'd2;
    #1;
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL prio_co: got %0b expected 0", co1); end
    edge_step(1'b1, 4'd2);
    n_vec++; if (q1 !== 4'd2) begin n_err++; $display("FAIL prio_q: got %0d expected 2", q1); end
  endtask

  task automatic test_invalid_load();
    edge_step(1'b1, 4'hC);
    n_vec++; if (q1 !== 4'd0 || seg1 !== 8'h3F) begin n_err++; $display("FAIL invalid_load: got %0d/%0h expected 0/3f", q1, seg1); end
    n_vec++; if (q4 !== 4'd0) begin n_err++; $display("FAIL invalid_load_div4: got %0d expected 0", q4); end
  endtask

  task automatic test_held_load();
    logic [3:0] d;
    for (int k = 0; k < 3; k++) begin
      d = 4'($urandom_range(0, 9));
      edge_step(1'b1, d);
      n_vec++; if (q1 !== d || q4 !== d) begin n_err++; $display("FAIL held_load: got %0d/%0d expected %0d", q1, q4, d); end
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp_a [10];
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      edge_step(1'b0, 4'd0);
      n_vec++; if (q4 !== 4'(m_cnt[1])) begin n_err++; $display("FAIL prescale_step edge %0d: got %0d expected %0d", e, q4, m_cnt[1]); end
      if (e == 4) begin
        n_vec++; if (q4 !== 4'd1) begin n_err++; $display("FAIL prescale_edge4: got %0d expected 1", q4); end
      end
      if (e == 8) begin
        n_vec++; if (q4 !== 4'd2) begin n_err++; $display("FAIL prescale_edge8: got %0d expected 2", q4); end
      end
    end
    exp_a = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      edge_step(e == 6, 4'd5);
      n_vec++; if (q4 !== exp_a[e-1]) begin n_err++; $display("FAIL prescale_reload edge %0d: got %0d expected %0d", e, q4, exp_a[e-1]); end
    end
  endtask

  task automatic test_random();
    logic       l;
    logic [3:0] d;
    for (int it = 0; it < 400; it++) begin
      l = ($urandom_range(0, 3) == 0);
      d = 4'($urandom_range(0, 15));
      load = l;
      din  = d;
      #1;
      n_vec++; if (q1 !== 4'(m_cnt[0]) || seg1 !== seg_tab[m_cnt[0]]) begin n_err++; $display("FAIL rand_dut1 it %0d: got %0d/%0h expected %0d/%0h", it, q1, seg1, m_cnt[0], seg_tab[m_cnt[0]]); end
      n_vec++; if (co1 !== m_co(0, l)) begin n_err++; $display("FAIL rand_co1 it %0d: got %0b expected %0b", it, co1, m_co(0, l)); end
      n_vec++; if (q4 !== 4'(m_cnt[1]) || seg4 !== seg_tab[m_cnt[1]]) begin n_err++; $display("FAIL rand_dut4 it %0d: got %0d/%0h expected %0d/%0h", it, q4, seg4, m_cnt[1], seg_tab[m_cnt[1]]); end
      n_vec++; if (co4 !== m_co(1, l)) begin n_err++; $display("FAIL rand_co4 it %0d: got %0b expected %0b", it, co4, m_co(1, l)); end
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++; if (q1 !== 4'd0 || q4 !== 4'd0 || co1 !== 1'b0 || co4 !== 1'b0) begin n_err++; $display("FAIL rand_reset it %0d: got %0d/%0d/%0b/%0b expected 0/0/0/0", it, q1, q4, co1, co4); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        edge_step(l, d);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    divs  = '{1, 4};
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    model_reset();
    rst  = 1'b1;
    load = 1'b0;
    din  = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_wrap();
    test_load();
    test_load_priority();
    test_invalid_load();
    test_held_load();
    test_prescale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
